// File: rtl/activation_writeback.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// activation_writeback
//
// Consumer end of the activation output interface. The activation stage emits
// one row as eight skewed lanes: lane 0 is qualified by in_data_available and
// lane k of the same row follows k cycles later. This block deskews the lanes
// into full rows and writes each accepted row to the output BRAM at
// consecutive addresses. It runs a start/busy/done handshake with the
// top-level controller.
//
// Timing reference: a row whose lane-0 strobe is sampled at edge T has its
// write registered at edge T+7, so the write is presented for exactly one
// cycle after that edge. done follows one cycle after the final write.
//
// Ports
//   clk               single clock, all logic on posedge
//   reset             synchronous, active-high
//   start             one-cycle pulse, honoured in IDLE or DONE only
//   base_addr         first write address, latched on an honoured start
//   num_rows          number of rows to collect, latched on an honoured start
//   in_data_available lane-0 valid strobe, one row per high cycle
//   inp_data0..7      lane data, lane k valid k cycles after its strobe
//   validity_mask     bit k = 0 disables lane k, latched on an honoured start
//   bram_addr         write address, holds its last value between writes
//   bram_wdata        row data, lane k in bits [(k+1)*DWIDTH-1 : k*DWIDTH]
//   bram_we           per-lane byte enables, zero in cycles without a write
//   busy              high while collecting
//   done              high in DONE, sticky until the next honoured start/reset
// -----------------------------------------------------------------------------
module activation_writeback #(
    parameter int DWIDTH     = 8,
    parameter int MASK_WIDTH = 8,
    parameter int AWIDTH     = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AWIDTH-1:0]       base_addr,
    input  logic [7:0]              num_rows,
    input  logic                    in_data_available,
    input  logic [DWIDTH-1:0]       inp_data0,
    input  logic [DWIDTH-1:0]       inp_data1,
    input  logic [DWIDTH-1:0]       inp_data2,
    input  logic [DWIDTH-1:0]       inp_data3,
    input  logic [DWIDTH-1:0]       inp_data4,
    input  logic [DWIDTH-1:0]       inp_data5,
    input  logic [DWIDTH-1:0]       inp_data6,
    input  logic [DWIDTH-1:0]       inp_data7,
    input  logic [MASK_WIDTH-1:0]   validity_mask,
    output logic [AWIDTH-1:0]       bram_addr,
    output logic [8*DWIDTH-1:0]     bram_wdata,
    output logic [MASK_WIDTH-1:0]   bram_we,
    output logic                    busy,
    output logic                    done
);

    // The lane count is fixed by the activation interface.
    localparam int LANES = 8;
    // Lane 0 needs the most delay: it waits for lane 7, which arrives 7 cycles
    // later and is used straight from the port.
    localparam int DEPTH = LANES - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Run parameters captured on an honoured start.
    logic [7:0]            rows_q;
    logic [MASK_WIDTH-1:0] mask_q;

    // Progress counters. accepted counts strobes taken into the pipeline,
    // written counts write cycles issued (including all-masked writes).
    logic [7:0]            accepted_q;
    logic [7:0]            written_q;
    logic [AWIDTH-1:0]     ptr_q;

    // Per-row accept flag travelling alongside the lane data.
    logic [DEPTH-1:0]      flag_sr;
    logic                  row_aligned;

    logic                  start_take;
    logic                  accept;

    logic [DWIDTH-1:0]     lane_in [LANES];
    logic [LANES-1:0][DWIDTH-1:0] lane_aligned;
    logic [8*DWIDTH-1:0]   wdata_masked;

    // -------------------------------------------------------------------------
    // Handshake and acceptance
    // -------------------------------------------------------------------------

    // A start pulse during collection is ignored; in IDLE and DONE it begins a
    // new run (possibly an empty one).
    assign start_take = start && (state_q != ST_COLLECT);

    // Strobes beyond the requested row count are dropped so they never reach
    // the BRAM.
    assign accept = in_data_available && (state_q == ST_COLLECT) &&
                    (accepted_q < rows_q);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this block samples the values from before the edge.
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and status outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_rows != 8'd0) ? ST_COLLECT : ST_DONE;
                end
            end

            ST_COLLECT: begin
                busy = 1'b1;
                // written_q already includes the final write here, so DONE is
                // entered on the edge after that write was registered.
                if (written_q == rows_q) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_d = (num_rows != 8'd0) ? ST_COLLECT : ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Run parameters and acceptance counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q     <= 8'd0;
            mask_q     <= '0;
            accepted_q <= 8'd0;
        end else if (start_take) begin
            rows_q     <= num_rows;
            mask_q     <= validity_mask;
            accepted_q <= 8'd0;
        end else if (accept) begin
            accepted_q <= accepted_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Deskew datapath
    // -------------------------------------------------------------------------
    assign lane_in[0] = inp_data0;
    assign lane_in[1] = inp_data1;
    assign lane_in[2] = inp_data2;
    assign lane_in[3] = inp_data3;
    assign lane_in[4] = inp_data4;
    assign lane_in[5] = inp_data5;
    assign lane_in[6] = inp_data6;
    assign lane_in[7] = inp_data7;

    // The flag enters stage 1 on the strobe edge and sits in stage 7 exactly
    // when lane 7 of the same row is on the port, so all lanes line up then.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_sr <= '0;
        end else begin
            flag_sr <= {flag_sr[DEPTH-2:0], accept};
        end
    end

    assign row_aligned = flag_sr[DEPTH-1];

    // Lane k gets 7-k stages: sampled k edges after the strobe, it reaches its
    // last stage on the same edge as lane 0 reaches stage 7.
    for (genvar k = 0; k < LANES - 1; k++) begin : g_lane_dly
        localparam int STAGES = DEPTH - k;

        logic [DWIDTH-1:0] pipe [STAGES];

        always_ff @(posedge clk) begin
            if (reset) begin
                // NOTE: the delay-line data is cleared as well, so every
                // register starts from a known value; whether a write happens
                // is decided by the flag pipeline alone.
                for (int i = 0; i < STAGES; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= lane_in[k];
                for (int i = 1; i < STAGES; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign lane_aligned[k] = pipe[STAGES-1];
    end

    assign lane_aligned[LANES-1] = lane_in[LANES-1];

    // Disabled lanes are written as zero so the BRAM never sees stale data on
    // a lane whose enable is low.
    always_comb begin
        wdata_masked = '0;
        for (int k = 0; k < LANES; k++) begin
            if (mask_q[k]) begin
                wdata_masked[k*DWIDTH +: DWIDTH] = lane_aligned[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered BRAM write port and write-side counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bram_addr  <= '0;
            bram_wdata <= '0;
            bram_we    <= '0;
            ptr_q      <= '0;
            written_q  <= 8'd0;
        end else begin
            // Enables are a single-cycle pulse; address and data hold.
            bram_we <= '0;

            // An honoured start only happens outside COLLECT, when no row is
            // in flight, so it never coincides with an aligned row.
            if (start_take) begin
                ptr_q     <= base_addr;
                written_q <= 8'd0;
            end

            if (row_aligned) begin
                // An all-zero mask still consumes a write slot and an address.
                bram_we    <= mask_q;
                bram_addr  <= ptr_q;
                bram_wdata <= wdata_masked;
                ptr_q      <= ptr_q + AWIDTH'(1);  // wraps modulo 2^AWIDTH
                written_q  <= written_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_activation_writeback.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_activation_writeback
//
// Stimulus drives rows as skewed lanes (unused lane slots carry random
// garbage). A transaction-level model decides which strobes are accepted and
// pushes the expected write, busy-rise and done-rise events into queues; an
// independent monitor on the falling edge pops and compares whenever the DUT
// shows a write, a busy rise or a done rise.
//
// Cycle bookkeeping: cyc equals n after posedge n. A strobe sampled at edge e
// must show its write after edge e+7 and, if it completes the run, done after
// edge e+8.
// -----------------------------------------------------------------------------
module tb_activation_writeback;

    localparam int DW    = 8;
    localparam int MW    = 8;
    localparam int AW    = 10;
    localparam int NEVER = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    num_rows;
    logic          in_data_available;
    logic [DW-1:0] lane [8];
    logic [MW-1:0] validity_mask;

    logic [AW-1:0]   bram_addr;
    logic [8*DW-1:0] bram_wdata;
    logic [MW-1:0]   bram_we;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    activation_writeback #(
        .DWIDTH    (DW),
        .MASK_WIDTH(MW),
        .AWIDTH    (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .num_rows         (num_rows),
        .in_data_available(in_data_available),
        .inp_data0        (lane[0]),
        .inp_data1        (lane[1]),
        .inp_data2        (lane[2]),
        .inp_data3        (lane[3]),
        .inp_data4        (lane[4]),
        .inp_data5        (lane[5]),
        .inp_data6        (lane[6]),
        .inp_data7        (lane[7]),
        .validity_mask    (validity_mask),
        .bram_addr        (bram_addr),
        .bram_wdata       (bram_wdata),
        .bram_we          (bram_we),
        .busy             (busy),
        .done             (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard queues
    // -------------------------------------------------------------------------
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [63:0]   data;
        logic [7:0]    we;
    } wr_t;

    wr_t  exp_wr[$];
    int   exp_done[$];
    int   exp_busy[$];

    // Row data by strobe edge, used to drive the skewed lanes.
    logic [63:0] row_at [int];

    // -------------------------------------------------------------------------
    // Reference model: run-level bookkeeping
    // -------------------------------------------------------------------------
    bit            m_has_run   = 1'b0;
    int            m_start_edge;
    int            m_done_edge;
    int            m_rows;
    int            m_acc;
    logic [7:0]    m_mask;
    logic [AW-1:0] m_ptr;
    logic [AW-1:0] m_last_addr = '0;

    // True when the block is collecting just before edge e.
    function automatic bit m_collecting(input int e);
        return m_has_run && (m_rows != 0) && (e > m_start_edge) && (e <= m_done_edge);
    endfunction

    function automatic logic [63:0] apply_mask(input logic [63:0] row, input logic [7:0] mask);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) r[k*8 +: 8] = row[k*8 +: 8];
        end
        return r;
    endfunction

    // Drive one cycle: update the model for the edge these inputs will be
    // sampled on, drive the skewed lanes, then advance past that edge.
    task automatic tick(input bit stb, input logic [63:0] row);
        int  e;
        bit  prev_in_done;
        wr_t w;
        e = cyc + 1;
        if (reset) begin
            exp_wr.delete();
            exp_done.delete();
            exp_busy.delete();
            m_has_run   = 1'b0;
            m_last_addr = '0;
        end else begin
            if (stb && m_collecting(e) && (m_acc < m_rows)) begin
                if (m_mask != 8'd0) begin
                    w.cyc  = e + 7;
                    w.addr = m_ptr;
                    w.data = apply_mask(row, m_mask);
                    w.we   = m_mask;
                    exp_wr.push_back(w);
                end
                m_last_addr = m_ptr;
                m_ptr       = m_ptr + 1'b1;
                m_acc++;
                if (m_acc == m_rows) begin
                    m_done_edge = e + 8;
                    exp_done.push_back(e + 8);
                end
            end
            if (start && !m_collecting(e)) begin
                prev_in_done = m_has_run;
                m_has_run    = 1'b1;
                m_start_edge = e;
                m_rows       = int'(num_rows);
                m_mask       = validity_mask;
                m_ptr        = base_addr;
                m_acc        = 0;
                if (num_rows == 8'd0) begin
                    m_done_edge = e;
                    if (!prev_in_done) exp_done.push_back(e);
                end else begin
                    m_done_edge = NEVER;
                    exp_busy.push_back(e);
                end
            end
        end
        if (stb) row_at[e] = row;
        in_data_available = stb;
        for (int k = 0; k < 8; k++) begin
            if (row_at.exists(e - k)) lane[k] = row_at[e - k][k*8 +: 8];
            else                      lane[k] = 8'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 64'd0);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [7:0] n, input logic [7:0] m);
        start         = 1'b1;
        base_addr     = b;
        num_rows      = n;
        validity_mask = m;
        tick(1'b0, 64'd0);
        start         = 1'b0;
        base_addr     = AW'($urandom);
        num_rows      = 8'($urandom);
        validity_mask = 8'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 64'd0);
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  bram_addr,  '0);
        check({tag, "_wdata"}, bram_wdata, '0);
        check({tag, "_we"},    bram_we,    '0);
        check({tag, "_busy"},  busy,       1'b0);
        check({tag, "_done"},  done,       1'b0);
    endtask

    // Run until every expected event has been observed (bounded), then check
    // that the address port holds the last issued address.
    task automatic drain();
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0 || exp_busy.size() != 0) && n < 300) begin
            tick(1'b0, 64'd0);
            n++;
        end
        check("drain_in_budget", 64'(n < 300), 64'd1);
        idle(2);
        check("addr_hold", bram_addr, m_last_addr);
    endtask

    function automatic logic [63:0] rnd_row();
        return {$urandom, $urandom};
    endfunction

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    logic prev_done = 1'b0;
    logic prev_busy = 1'b0;
    wr_t  mw;

    always @(negedge clk) begin
        if (bram_we !== '0) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                mw = exp_wr.pop_front();
                check("write_cycle", 64'(cyc), 64'(mw.cyc));
                check("write_addr",  bram_addr,  mw.addr);
                check("write_data",  bram_wdata, mw.data);
                check("write_we",    bram_we,    mw.we);
            end
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            if (exp_done.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else                      check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
            check("busy_low_at_done", busy, 1'b0);
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            if (exp_busy.size() == 0) check("unexpected_busy", 64'd1, 64'd0);
            else                      check("busy_cycle", 64'(cyc), 64'(exp_busy.pop_front()));
            check("done_low_at_busy", done, 1'b0);
        end
        prev_done = done;
        prev_busy = busy;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int strobes;
        int target;
        reset             = 1'b1;
        start             = 1'b0;
        base_addr         = '0;
        num_rows          = '0;
        validity_mask     = '0;
        in_data_available = 1'b0;
        for (int k = 0; k < 8; k++) lane[k] = '0;

        // Reset state.
        tick(1'b0, 64'd0);
        tick(1'b0, 64'd0);
        reset = 1'b0;
        check_reset_outputs("reset_state");

        // Single row with a two-cycle strobe delay.
        do_start(10'h010, 8'd1, 8'hFF);
        idle(2);
        tick(1'b1, 64'h1716151413121110);
        drain();

        // Back-to-back rows.
        do_start(10'h120, 8'd3, 8'hFF);
        tick(1'b1, rnd_row());
        tick(1'b1, rnd_row());
        tick(1'b1, rnd_row());
        drain();

        // Partial mask.
        do_start(10'h200, 8'd1, 8'hA5);
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        // Extra strobes: only the first two are written.
        do_start(10'h040, 8'd2, 8'hFF);
        for (int i = 0; i < 4; i++) tick(1'b1, rnd_row());
        drain();
        // Strobe while in DONE.
        tick(1'b1, rnd_row());
        idle(12);

        // Start during collection is ignored.
        do_start(10'h080, 8'd2, 8'h3C);
        tick(1'b1, rnd_row());
        start     = 1'b1;
        base_addr = 10'h300;
        num_rows  = 8'd5;
        tick(1'b1, rnd_row());
        start     = 1'b0;
        drain();

        // Zero rows from IDLE: done the cycle after start, strobes ignored.
        do_reset();
        do_start(10'h000, 8'd0, 8'hFF);
        tick(1'b1, rnd_row());
        tick(1'b1, rnd_row());
        idle(10);
        drain();

        // All-zero mask: no enables, but rows still count and advance address.
        do_start(10'h155, 8'd3, 8'h00);
        tick(1'b1, rnd_row());
        idle(1);
        tick(1'b1, rnd_row());
        tick(1'b1, rnd_row());
        drain();

        // Reset with a row in flight.
        do_start(10'h0AA, 8'd1, 8'hFF);
        tick(1'b1, rnd_row());
        idle(3);
        do_reset();
        check_reset_outputs("mid_reset");
        idle(10);
        drain();

        // Address wrap.
        do_start(10'h3FF, 8'd2, 8'hFF);
        tick(1'b1, rnd_row());
        idle(1);
        tick(1'b1, rnd_row());
        drain();

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            do_start(AW'($urandom), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 255)));
            strobes = 0;
            target  = int'(m_rows) + int'($urandom_range(0, 2));
            while (strobes < target) begin
                if ($urandom_range(0, 9) < 6) begin
                    tick(1'b1, rnd_row());
                    strobes++;
                end else begin
                    tick(1'b0, 64'd0);
                end
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
